// File: rtl/counter_sequencer.sv
// counter_sequencer: run-control sequencer driving the enable/clear of a W-bit counter
// Ports: clk/reset (sync, active-high); start/stop/pause strobes; mode/limit/reps run setup;
//        count from the counter; cnt_ena/cnt_clr to the counter; busy, tc_pulse, done, err,
//        reps_done status.
module counter_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode,
  input  logic [W-1:0] limit,
  input  logic [7:0]   reps,
  input  logic [W-1:0] count,
  output logic         cnt_ena,
  output logic         cnt_clr,
  output logic         busy,
  output logic         tc_pulse,
  output logic         done,
  output logic         err,
  output logic [7:0]   reps_done
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WRAP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]   r_state, w_next;
  logic         r_mode, r_err;
  logic [W-1:0] r_limit;
  logic [7:0]   r_reps, r_reps_done;
  logic         w_accept, w_hit, w_last;
  assign w_accept  = (r_state == S_IDLE) & start & ~stop & (limit != '0);
  assign busy      = r_state != S_IDLE;
  assign cnt_ena   = (r_state == S_RUN) & ~pause & ~stop;
  assign cnt_clr   = ((r_state == S_CLEAR) | (r_state == S_WRAP)) & ~stop;
  assign tc_pulse  = ((r_state == S_WRAP) | (r_state == S_DONE)) & ~stop;
  assign done      = (r_state == S_DONE) & ~stop;
  assign err       = r_err;
  assign reps_done = r_reps_done;
  assign w_hit     = cnt_ena & (count == r_limit - W'(1));
  // 9-bit sum so a saturated reps_done can never alias onto a small reps value
  assign w_last    = ~r_mode | ((r_reps != 8'd0) & ({1'b0, r_reps_done} + 9'd1 == {1'b0, r_reps}));
  // stop returns to IDLE from anywhere; undefined encodings also fall back to IDLE
  always_comb begin
    w_next = stop                 ? S_IDLE :
             r_state == S_IDLE    ? (w_accept ? S_CLEAR : S_IDLE) :
             r_state == S_CLEAR   ? S_RUN :
             r_state == S_RUN     ? (w_hit ? (w_last ? S_DONE : S_WRAP) : S_RUN) :
             r_state == S_WRAP    ? S_RUN : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_limit     <= '0;
      r_reps      <= '0;
      r_reps_done <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE) & start & ~stop & (limit == '0);
      if (w_accept) begin
        r_mode      <= mode;
        r_limit     <= limit;
        r_reps      <= reps;
        r_reps_done <= '0;
      end else if (tc_pulse && r_reps_done != 8'hff) begin
        r_reps_done <= r_reps_done + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed self-checking bench with a behavioural counter model
module tb_counter_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, mode = 1'b0;
  logic [15:0] limit = '0, count = '0;
  logic [7:0]  reps = '0, reps_done;
  logic        cnt_ena, cnt_clr, busy, tc_pulse, done, err;
  int          n_run = 0, n_fail = 0;
  counter_sequencer #(.W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .mode(mode),
    .limit(limit), .reps(reps), .count(count), .cnt_ena(cnt_ena), .cnt_clr(cnt_clr),
    .busy(busy), .tc_pulse(tc_pulse), .done(done), .err(err), .reps_done(reps_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) count <= cnt_clr ? 16'd0 : cnt_ena ? count + 16'd1 : count;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ena"}, cnt_ena, 0);
    chk({tag, "_clr"}, cnt_clr, 0);
    chk({tag, "_tc"}, tc_pulse, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_reps"}, reps_done, 0);
  endtask
  initial begin
    repeat (2) tick();
    reset = 1'b0;
    #1 chk_idle("rst");
    // one-shot L=4; a start with new setup mid-run must be ignored
    start = 1'b1; mode = 1'b0; limit = 16'd4;
    tick(); start = 1'b0; #1;
    chk("os_clr", cnt_clr, 1); chk("os_busy1", busy, 1); chk("os_ena1", cnt_ena, 0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 3) begin start = 1'b1; mode = 1'b1; limit = 16'd9; end
      #1;
      chk("os_ena", cnt_ena, 1); chk("os_cnt", count, c - 2);
      start = 1'b0;
    end
    tick(); #1;
    chk("os_done", done, 1); chk("os_tc", tc_pulse, 1); chk("os_cnt4", count, 4); chk("os_ena6", cnt_ena, 0);
    tick(); #1;
    chk("os_busy7", busy, 0); chk("os_reps", reps_done, 1); chk("os_done7", done, 0); chk("os_hold", count, 4);
    // periodic L=3, reps=3
    start = 1'b1; mode = 1'b1; limit = 16'd3; reps = 8'd3;
    tick(); start = 1'b0; #1;
    for (int c = 1; c <= 13; c++) begin
      chk("per_tc", tc_pulse, (c == 5 || c == 9 || c == 13));
      chk("per_clr", cnt_clr, (c == 1 || c == 5 || c == 9));
      chk("per_done", done, (c == 13));
      if (c == 5 || c == 9 || c == 13) chk("per_cnt", count, 3);
      if (c < 13) begin tick(); #1; end
    end
    tick(); #1;
    chk("per_busy", busy, 0); chk("per_reps", reps_done, 3); chk("per_hold", count, 3);
    // one-shot L=4 with a 2-cycle pause while count=2
    start = 1'b1; mode = 1'b0; limit = 16'd4; reps = 8'd0;
    tick(); start = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      pause = (c == 4 || c == 5);
      #1;
      chk("pz_cnt", count, c <= 4 ? c - 2 : c <= 6 ? 2 : c - 4);
      chk("pz_ena", cnt_ena, (c >= 2 && c <= 7 && c != 4 && c != 5));
      chk("pz_done", done, (c == 8));
    end
    pause = 1'b0;
    tick();
    // stop in the terminal cycle of a periodic run
    start = 1'b1; mode = 1'b1; limit = 16'd3;
    tick(); start = 1'b0;
    repeat (3) tick();
    stop = 1'b1; #1;
    chk("st_cnt", count, 2); chk("st_ena", cnt_ena, 0); chk("st_tc", tc_pulse, 0);
    chk("st_done", done, 0); chk("st_clr", cnt_clr, 0); chk("st_busy", busy, 1);
    tick(); stop = 1'b0; #1;
    chk("st_idle", busy, 0); chk("st_hold", count, 2); chk("st_tc2", tc_pulse, 0);
    // start together with stop in IDLE
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0; #1;
    chk("ss_busy", busy, 0); chk("ss_err", err, 0);
    // rejected start with L=0
    start = 1'b1; limit = 16'd0;
    tick(); start = 1'b0; #1;
    chk("z_err", err, 1); chk("z_busy", busy, 0);
    tick(); #1;
    chk("z_err2", err, 0);
    // periodic unlimited, 300+ periods of L=1: reps_done saturates
    start = 1'b1; mode = 1'b1; limit = 16'd1; reps = 8'd0;
    tick(); start = 1'b0;
    repeat (650) tick();
    chk("sat_reps", reps_done, 8'hff); chk("sat_busy", busy, 1);
    // reset mid-run clears everything
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    chk_idle("rst2");
    // normal one-shot L=2 after reset
    start = 1'b1; mode = 1'b0; limit = 16'd2;
    tick(); start = 1'b0;
    repeat (3) tick();
    chk("ar_done", done, 1); chk("ar_cnt", count, 2);
    tick();
    chk("ar_busy", busy, 0); chk("ar_reps", reps_done, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
